// File: rtl/alien_swarm_mover.sv
// Swarm pacing and position tracker that partners the zig-zag motion FSM.
// Optional macro SWARM_SPEEDUP_EN shortens the step period on each applied DOWN.
module alien_swarm_mover #(
    parameter int TICK_DIV = 2500000,
    parameter int TICK_MIN = 500000,
    parameter int X_START  = 0,
    parameter int Y_START  = 32,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 320,
    parameter int STEP_X   = 8,
    parameter int STEP_Y   = 16,
    parameter int Y_LIMIT  = 400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [1:0] motion,
    output logic       step_en,
    output logic       can_left,
    output logic       can_right,
    output logic [9:0] swarm_x,
    output logic [9:0] swarm_y,
    output logic       landed
);

    localparam logic [1:0] MOVE_LEFT  = 2'd1;
    localparam logic [1:0] MOVE_RIGHT = 2'd2;
    localparam logic [1:0] MOVE_DOWN  = 2'd3;

    // 11-bit working width so x+STEP_X and y+STEP_Y never wrap
    localparam logic [10:0] X_START_W = 11'(X_START);
    localparam logic [10:0] Y_START_W = 11'(Y_START);
    localparam logic [10:0] X_MIN_W   = 11'(X_MIN);
    localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
    localparam logic [10:0] STEP_X_W  = 11'(STEP_X);
    localparam logic [10:0] STEP_Y_W  = 11'(STEP_Y);
    localparam logic [10:0] Y_LIMIT_W = 11'(Y_LIMIT);

    logic [31:0] count_reg;
    logic [31:0] period;
    logic        step_en_reg;
    logic        pending_reg;
    logic        landed_reg;
    logic [10:0] x_reg, x_next;
    logic [10:0] y_reg, y_next;
    logic        counting;
    logic        fire;
    logic        apply;

    assign counting = run && !landed_reg;
    assign apply    = pending_reg && !landed_reg;

`ifdef SWARM_SPEEDUP_EN
    localparam logic [31:0] PERIOD_DEC = 32'(TICK_DIV >> 3);
    localparam logic [31:0] PERIOD_MIN = 32'(TICK_MIN);
    logic [31:0] period_reg;

    assign period = period_reg;
    // >= so a period that shrinks below the running count still fires at once
    assign fire   = counting && (count_reg >= period - 32'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            period_reg <= 32'(TICK_DIV);
        end else if (apply && motion == MOVE_DOWN) begin
            period_reg <= (period_reg >= PERIOD_MIN + PERIOD_DEC) ?
                          period_reg - PERIOD_DEC : PERIOD_MIN;
        end
    end
`else
    assign period = 32'(TICK_DIV);
    assign fire   = counting && (count_reg == period - 32'd1);
`endif

    // Saturating moves; comparisons come first so nothing underflows
    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (apply) begin
            case (motion)
                MOVE_LEFT:  x_next = (x_reg >= X_MIN_W + STEP_X_W) ? x_reg - STEP_X_W : X_MIN_W;
                MOVE_RIGHT: x_next = (x_reg + STEP_X_W <= X_MAX_W) ? x_reg + STEP_X_W : X_MAX_W;
                MOVE_DOWN:  y_next = (y_reg + STEP_Y_W <= Y_LIMIT_W) ? y_reg + STEP_Y_W : Y_LIMIT_W;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg   <= 32'd0;
            step_en_reg <= 1'b0;
            pending_reg <= 1'b0;
            landed_reg  <= 1'b0;
            x_reg       <= X_START_W;
            y_reg       <= Y_START_W;
        end else begin
            step_en_reg <= fire;
            pending_reg <= step_en_reg;
            if (counting) begin
                count_reg <= fire ? 32'd0 : count_reg + 32'd1;
            end
            x_reg <= x_next;
            y_reg <= y_next;
            if (apply && y_next >= Y_LIMIT_W) begin
                landed_reg <= 1'b1;
            end
        end
    end

    assign step_en   = step_en_reg;
    assign swarm_x   = x_reg[9:0];
    assign swarm_y   = y_reg[9:0];
    assign landed    = landed_reg;
    assign can_left  = (x_reg >= X_MIN_W + STEP_X_W);
    assign can_right = (x_reg + STEP_X_W <= X_MAX_W);

endmodule

// File: doc/alien_swarm_mover.md
Name: alien_swarm_mover

Overview:
Downstream partner of the zig-zag alien motion FSM. It paces the swarm by issuing a one-cycle step pulse to the FSM's enable input. It applies the 2-bit motion code the FSM returns to the swarm's bounding-box position registers. It feeds boundary flags (can_left/can_right) back to the FSM, and it raises a sticky landed flag when the swarm reaches the invasion line.

Parameters:
TICK_DIV, 2500000, clock cycles per swarm step (≥2)
TICK_MIN, 500000, minimum step period (used only with SWARM_SPEEDUP_EN)
X_START, 0, swarm left-edge x after reset
Y_START, 32, swarm top-edge y after reset
X_MIN, 0, leftmost allowed swarm x
X_MAX, 320, rightmost allowed swarm x (screen width − swarm width)
STEP_X, 8, pixels per horizontal step
STEP_Y, 16, pixels per down step
Y_LIMIT, 400, invasion line; swarm y ≥ Y_LIMIT means landed

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
run  in  1  game active; low freezes pacing
motion  in  2  from FSM: 0 none, 1 left, 2 right, 3 down
step_en  out  1  one-cycle pulse to FSM enable
can_left  out  1  a full left step fits
can_right  out  1  a full right step fits
swarm_x  out  10  swarm left edge
swarm_y  out  10  swarm top edge
landed  out  1  sticky invasion flag

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset values: swarm_x=X_START, swarm_y=Y_START, step_en=0, landed=0, tick counter=0, pending-apply flag=0, period=TICK_DIV.
- Tick counter counts 0..period−1 while run=1 && landed=0. It holds its value when run=0 and does not clear.
- At an edge where count==period−1 (and counting is allowed): count<=0 and step_en<=1, so step_en is registered and high for exactly one cycle. With run=1, pulses occur every period cycles; the first one is high in cycle TICK_DIV after reset is released.
- Apply latency:
  - step_en high in cycle N; the FSM updates its state at the end of N; motion is valid in cycle N+1.
  - The block sets pending<=step_en and applies motion at the end of N+1, so the new position is visible in N+2.
- A pending apply completes even if run has dropped. Reset in cycle N+1 cancels the apply.
- Apply rules (saturating, no wrap):
  - 1: swarm_x <= max(swarm_x−STEP_X, X_MIN).
  - 2: swarm_x <= min(swarm_x+STEP_X, X_MAX).
  - 3: swarm_y <= min(swarm_y+STEP_Y, Y_LIMIT).
  - 0: hold.
- Perform the subtraction so that it never underflows; compare before subtracting.
- can_left = (swarm_x ≥ X_MIN+STEP_X). can_right = (swarm_x+STEP_X ≤ X_MAX). Both are combinational from the position registers and valid during reset-release.
- landed: set at the apply edge where the new swarm_y ≥ Y_LIMIT. It is cleared only by reset. While landed=1, step_en stays 0 and the position is frozen.
- A motion value that arrives without pending=1 is ignored.

Optional Feature:
- Macro: SWARM_SPEEDUP_EN.
- Defined: period is a register. Each applied DOWN sets period <= max(period − (TICK_DIV>>3), TICK_MIN). The counter compares with ≥ (count ≥ period−1 fires and clears), so a shrinking period never causes a missed or wrapped pulse.
- Undefined: period is the constant TICK_DIV, TICK_MIN is unused, and no period register is synthesised.

Test Plan:
(Bench parameters: TICK_DIV=4, X_START=0, Y_START=0, X_MIN=0, X_MAX=24, STEP_X=8, STEP_Y=16, Y_LIMIT=48.)
1. Release reset with run=1 and motion=0 → outputs are x=0, y=0, can_left=0, can_right=1, landed=0. step_en is a single-cycle pulse in cycles 4, 8, 12, …; position never changes.
2. Hold motion=2 and drive it one cycle after each step_en → x goes 8, 16, 24, each visible two cycles after step_en. can_right=0 once x=24. A further RIGHT leaves x at 24.
3. From x=24, hold motion=1 → x goes 16, 8, 0; can_left=0 at x=0. A further LEFT keeps x=0 with no underflow.
4. Drive motion=3 on three steps → y goes 16, 32, 48. landed=1 on the edge y becomes 48. Afterwards step_en never pulses over 50 cycles with run=1, and x/y are frozen.
5. Drop run when count=2, hold low for 10 cycles, then raise it → no step_en while low. The next step_en comes 2 cycles after run rises (count resumes from 2).
6. Assert reset in the cycle after step_en while motion=2 → the apply is cancelled; x=0, y=0, landed=0, and the next step_en is 4 cycles after reset release.
7. With SWARM_SPEEDUP_EN (TICK_DIV=16, TICK_MIN=8), apply three DOWNs → the period goes 14, 12, 10. After the next three DOWNs it saturates at 8. The step_en spacing matches each new period.
